// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Constants shared by the UART receive path: the width of the rx error code,
// the error-code values rx reports (zero means a clean frame), the width of
// the error-frame counter, and a saturating increment for that counter.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_ERR_W     = 3;
  localparam int UART_ERR_CNT_W = 8;

  typedef logic [UART_ERR_W-1:0]     uart_err_t;
  typedef logic [UART_ERR_CNT_W-1:0] uart_err_cnt_t;

  // Error codes as reported by rx; bits may combine.
  localparam uart_err_t UART_ERR_NONE   = 3'b000;
  localparam uart_err_t UART_ERR_FRAME  = 3'b001;
  localparam uart_err_t UART_ERR_PARITY = 3'b010;
  localparam uart_err_t UART_ERR_BREAK  = 3'b100;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic uart_err_cnt_t err_cnt_sat_inc(input uart_err_cnt_t v);
    if (v == '1) begin
      return v;
    end
    return v + uart_err_cnt_t'(1);
  endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// ---------------------------------------------------------------------------
// uart_sync_edge
// Brings a slow strobe from another clock domain into i_Clk through a 2-FF
// synchronizer and emits a one-cycle pulse on its rising edge.
// Ports:
//   i_Clk   : destination clock
//   i_Rst   : asynchronous, active-high reset
//   i_Async : strobe from the foreign domain
//   o_Rise  : high for one i_Clk cycle, the cycle after the second
//             synchronizer stage first holds 1
// ---------------------------------------------------------------------------
module uart_sync_edge (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Async,
  output logic o_Rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= i_Async;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // A level held high yields one pulse; a new pulse needs a low in between.
  assign o_Rise = sync_q & ~prev_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side frame buffer downstream of the UART rx stage. Each rising edge
// of the rx valid strobe (after synchronization) captures one frame (data
// plus error code) into a first-word-fall-through FIFO with a valid/ready
// read port. Tracks occupancy, a sticky overflow flag and a saturating count
// of frames received with a nonzero error code.
// Ports:
//   i_Clk, i_Rst             : clock, asynchronous active-high reset
//   i_RX_valid/byte/error    : frame strobe and payload from the rx domain
//   o_Data, o_Err, o_Valid   : head-of-queue frame, present when o_Valid
//   i_Ready                  : consumer takes the head when o_Valid & i_Ready
//   o_Count, o_Full, o_Empty : occupancy 0..DEPTH and its extremes
//   o_Overflow, i_Clr_Ovf    : sticky frame-lost flag and its clear
//   o_Err_Cnt                : saturating count of error frames
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int DROP_ERR = 0
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  input  logic                      i_RX_valid,
  input  logic [DATA_W-1:0]         i_RX_byte,
  input  logic [UART_ERR_W-1:0]     i_RX_error,
  output logic [DATA_W-1:0]         o_Data,
  output logic [UART_ERR_W-1:0]     o_Err,
  output logic                      o_Valid,
  input  logic                      i_Ready,
  output logic [$clog2(DEPTH):0]    o_Count,
  output logic                      o_Full,
  output logic                      o_Empty,
  output logic                      o_Overflow,
  input  logic                      i_Clr_Ovf,
  output logic [UART_ERR_CNT_W-1:0] o_Err_Cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage is deliberately not reset.
  logic [DATA_W-1:0]     data_mem [DEPTH];
  logic [UART_ERR_W-1:0] err_mem  [DEPTH];

  logic [AW-1:0]         wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q,  rd_ptr_d;
  logic [CW-1:0]         count_q,   count_d;
  logic                  ovf_q,     ovf_d;
  uart_err_cnt_t         err_cnt_q, err_cnt_d;

  logic push;
  logic pop;
  logic full;
  logic empty;
  logic frame_err;
  logic discard;
  logic wr_en;
  logic lost;

  uart_sync_edge u_sync (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Async (i_RX_valid),
    .o_Rise  (push)
  );

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign frame_err = (i_RX_error != UART_ERR_NONE);
  assign discard   = (DROP_ERR != 0) && frame_err;
  assign pop       = !empty && i_Ready;

  // A full FIFO still accepts a frame when the head leaves on the same edge.
  assign wr_en = push && !discard && (!full || pop);
  assign lost  = push && !discard && full && !pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    err_cnt_d = err_cnt_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Set wins over clear when both happen on the same edge.
    if (i_Clr_Ovf) begin
      ovf_d = 1'b0;
    end
    if (lost) begin
      ovf_d = 1'b1;
    end

    // Error frames are counted whether or not they end up stored.
    if (push && frame_err) begin
      err_cnt_d = err_cnt_sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // The payload is sampled on the write edge itself, two edges after the
  // synchronizer first sees valid, while rx still holds it stable.
  always_ff @(posedge i_Clk) begin
    if (wr_en) begin
      data_mem[wr_ptr_q] <= i_RX_byte;
      err_mem[wr_ptr_q]  <= i_RX_error;
    end
  end

  assign o_Data     = data_mem[rd_ptr_q];
  assign o_Err      = err_mem[rd_ptr_q];
  assign o_Valid    = !empty;
  assign o_Count    = count_q;
  assign o_Full     = full;
  assign o_Empty    = empty;
  assign o_Overflow = ovf_q;
  assign o_Err_Cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Bench for uart_rx_fifo. Two instances share all inputs: u_keep queues error
// frames, u_drop discards them. A queue-based reference model tracks the
// expected contents, overflow flag and error count of each instance.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  typedef struct {
    logic [7:0] d;
    logic [2:0] e;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [2:0] rx_err;
  logic       ready;
  logic       clr;

  logic [7:0] k_data,  d_data;
  logic [2:0] k_err,   d_err;
  logic       k_valid, d_valid;
  logic [4:0] k_count, d_count;
  logic       k_full,  d_full;
  logic       k_empty, d_empty;
  logic       k_ovf,   d_ovf;
  logic [7:0] k_ecnt,  d_ecnt;

  frame_t qk[$];
  frame_t qd[$];
  int     m_ecnt;
  logic   m_ovfk, m_ovfd;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .DROP_ERR(0)) u_keep (
    .i_Clk(clk), .i_Rst(rst), .i_RX_valid(rx_valid), .i_RX_byte(rx_byte),
    .i_RX_error(rx_err), .o_Data(k_data), .o_Err(k_err), .o_Valid(k_valid),
    .i_Ready(ready), .o_Count(k_count), .o_Full(k_full), .o_Empty(k_empty),
    .o_Overflow(k_ovf), .i_Clr_Ovf(clr), .o_Err_Cnt(k_ecnt)
  );

  uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .DROP_ERR(1)) u_drop (
    .i_Clk(clk), .i_Rst(rst), .i_RX_valid(rx_valid), .i_RX_byte(rx_byte),
    .i_RX_error(rx_err), .o_Data(d_data), .o_Err(d_err), .o_Valid(d_valid),
    .i_Ready(ready), .o_Count(d_count), .o_Full(d_full), .o_Empty(d_empty),
    .o_Overflow(d_ovf), .i_Clr_Ovf(clr), .o_Err_Cnt(d_ecnt)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_clear();
    qk.delete();
    qd.delete();
    m_ecnt = 0;
    m_ovfk = 1'b0;
    m_ovfd = 1'b0;
  endtask

  // One received frame; popw/clrw say whether the consumer popped or cleared
  // overflow on the same edge the frame is written.
  task automatic model_frame(input logic [7:0] d, input logic [2:0] e,
                             input bit popw, input bit clrw);
    frame_t f;
    f.d = d;
    f.e = e;
    if (e != 3'd0 && m_ecnt < 255) m_ecnt++;
    if (popw) begin
      if (qk.size() > 0) void'(qk.pop_front());
      if (qd.size() > 0) void'(qd.pop_front());
    end
    if (clrw) begin
      m_ovfk = 1'b0;
      m_ovfd = 1'b0;
    end
    if (qk.size() < DEPTH) qk.push_back(f);
    else m_ovfk = 1'b1;
    if (e == 3'd0) begin
      if (qd.size() < DEPTH) qd.push_back(f);
      else m_ovfd = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; rx_byte = '0; rx_err = '0; ready = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
  endtask

  // Valid held high across four edges; the write edge is the third of them.
  task automatic send_frame(input logic [7:0] d, input logic [2:0] e,
                            input bit popw, input bit clrw);
    @(negedge clk);
    rx_valid = 1'b1; rx_byte = d; rx_err = e;
    @(negedge clk);
    @(negedge clk);
    ready = popw;
    clr   = clrw;
    @(negedge clk);
    ready = 1'b0;
    clr   = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    model_frame(d, e, popw, clrw);
  endtask

  task automatic pop_one();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    if (qk.size() > 0) void'(qk.pop_front());
    if (qd.size() > 0) void'(qd.pop_front());
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_byte = '0; rx_err = '0; ready = 1'b0; clr = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (k_valid !== 1'b0 || k_empty !== 1'b1 || k_full !== 1'b0 || k_count !== 5'd0 ||
        k_ovf !== 1'b0 || k_ecnt !== 8'd0)
      $display("FAIL reset: valid=%b empty=%b full=%b count=%0d ovf=%b ecnt=%0d want 0 1 0 0 0 0",
               k_valid, k_empty, k_full, k_count, k_ovf, k_ecnt);
    else n_pass++;
  endtask

  task automatic test_single_capture();
    do_reset();
    @(negedge clk);
    rx_valid = 1'b1; rx_byte = 8'hA5; rx_err = 3'd0;
    @(negedge clk);                      // first sampling edge passed
    @(negedge clk);                      // second edge passed: push pending
    n_checks++;
    if (k_valid !== 1'b0) $display("FAIL capture_early: valid=%b want 0", k_valid);
    else n_pass++;
    @(negedge clk);                      // write edge passed
    n_checks++;
    if (k_valid !== 1'b1 || k_data !== 8'hA5 || k_count !== 5'd1)
      $display("FAIL capture_write: valid=%b data=%h count=%0d want 1 a5 1", k_valid, k_data, k_count);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    model_frame(8'hA5, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (k_count !== 5'(qk.size()))
      $display("FAIL capture_once: count=%0d want %0d", k_count, qk.size());
    else n_pass++;
    pop_one();
    n_checks++;
    if (k_empty !== 1'b1 || k_valid !== 1'b0)
      $display("FAIL capture_pop: empty=%b valid=%b want 1 0", k_empty, k_valid);
    else n_pass++;
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) send_frame(8'(i), 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (k_full !== 1'b1 || k_count !== 5'd16 || k_ovf !== 1'b0)
      $display("FAIL fill: full=%b count=%0d ovf=%b want 1 16 0", k_full, k_count, k_ovf);
    else n_pass++;
    send_frame(8'h10, 3'd0, 1'b0, 1'b0);
    n_checks++;
    if (k_ovf !== m_ovfk || k_count !== 5'd16 || k_full !== 1'b1)
      $display("FAIL overflow: ovf=%b count=%0d want %b 16", k_ovf, k_count, m_ovfk);
    else n_pass++;
    while (qk.size() > 0) begin
      n_checks++;
      if (k_valid !== 1'b1 || k_data !== qk[0].d || k_err !== qk[0].e)
        $display("FAIL ovf_drain: valid=%b data=%h err=%b want 1 %h %b",
                 k_valid, k_data, k_err, qk[0].d, qk[0].e);
      else n_pass++;
      pop_one();
    end
    n_checks++;
    if (k_empty !== 1'b1 || k_count !== 5'd0)
      $display("FAIL ovf_drain_end: empty=%b count=%0d want 1 0", k_empty, k_count);
    else n_pass++;
  endtask

  task automatic test_full_pop_and_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) send_frame(8'($urandom), 3'd0, 1'b0, 1'b0);
    send_frame(8'h55, 3'd0, 1'b1, 1'b0);
    n_checks++;
    if (k_ovf !== 1'b0 || k_count !== 5'd16 || qk[15].d !== 8'h55)
      $display("FAIL full_pop: ovf=%b count=%0d want 0 16", k_ovf, k_count);
    else n_pass++;
    while (qk.size() > 0) begin
      n_checks++;
      if (k_data !== qk[0].d || k_valid !== 1'b1)
        $display("FAIL full_pop_drain: data=%h valid=%b want %h 1", k_data, k_valid, qk[0].d);
      else n_pass++;
      pop_one();
    end
    for (int i = 0; i < 40; i++) begin
      send_frame(8'($urandom), 3'd0, 1'b0, 1'b0);
      if (qk.size() >= 6 + (i % 3)) begin
        n_checks++;
        if (k_data !== qk[0].d || k_count !== 5'(qk.size()))
          $display("FAIL wrap: data=%h count=%0d want %h %0d", k_data, k_count, qk[0].d, qk.size());
        else n_pass++;
        pop_one();
      end
    end
    while (qk.size() > 0) begin
      n_checks++;
      if (k_data !== qk[0].d)
        $display("FAIL wrap_drain: data=%h want %h", k_data, qk[0].d);
      else n_pass++;
      pop_one();
    end
    n_checks++;
    if (k_ovf !== 1'b0 || k_empty !== 1'b1)
      $display("FAIL wrap_end: ovf=%b empty=%b want 0 1", k_ovf, k_empty);
    else n_pass++;
  endtask

  task automatic test_error_frames();
    do_reset();
    send_frame(8'h3C, 3'b010, 1'b0, 1'b0);
    n_checks++;
    if (k_count !== 5'd1 || k_data !== 8'h3C || k_err !== 3'b010 || k_ecnt !== 8'd1)
      $display("FAIL err_keep: count=%0d data=%h err=%b ecnt=%0d want 1 3c 010 1",
               k_count, k_data, k_err, k_ecnt);
    else n_pass++;
    n_checks++;
    if (d_count !== 5'd0 || d_valid !== 1'b0 || d_ecnt !== 8'd1)
      $display("FAIL err_drop: count=%0d valid=%b ecnt=%0d want 0 0 1", d_count, d_valid, d_ecnt);
    else n_pass++;
    for (int i = 0; i < 6; i++)
      send_frame(8'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
    n_checks++;
    if (k_count !== 5'(qk.size()) || d_count !== 5'(qd.size()) ||
        k_ecnt !== 8'(m_ecnt) || d_ecnt !== 8'(m_ecnt))
      $display("FAIL err_mix: kcount=%0d dcount=%0d kecnt=%0d decnt=%0d want %0d %0d %0d",
               k_count, d_count, k_ecnt, d_ecnt, qk.size(), qd.size(), m_ecnt);
    else n_pass++;
    while (qk.size() > 0 || qd.size() > 0) begin
      if (qd.size() > 0) begin
        n_checks++;
        if (d_data !== qd[0].d || d_err !== 3'd0)
          $display("FAIL err_drop_drain: data=%h err=%b want %h 000", d_data, d_err, qd[0].d);
        else n_pass++;
      end
      if (qk.size() > 0) begin
        n_checks++;
        if (k_data !== qk[0].d || k_err !== qk[0].e)
          $display("FAIL err_keep_drain: data=%h err=%b want %h %b", k_data, k_err, qk[0].d, qk[0].e);
        else n_pass++;
      end
      pop_one();
    end
  endtask

  task automatic test_saturate_and_clear();
    do_reset();
    for (int i = 0; i < 300; i++)
      send_frame(8'($urandom), 3'($urandom_range(1, 7)), 1'b0, 1'b0);
    n_checks++;
    if (k_ecnt !== 8'(m_ecnt) || d_ecnt !== 8'(m_ecnt) || m_ecnt != 255)
      $display("FAIL sat: kecnt=%0d decnt=%0d want %0d", k_ecnt, d_ecnt, m_ecnt);
    else n_pass++;
    n_checks++;
    if (k_ovf !== m_ovfk || k_count !== 5'd16 || d_count !== 5'd0 || d_ovf !== m_ovfd)
      $display("FAIL sat_state: kovf=%b kcount=%0d dcount=%0d dovf=%b want %b 16 0 %b",
               k_ovf, k_count, d_count, d_ovf, m_ovfk, m_ovfd);
    else n_pass++;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    m_ovfk = 1'b0; m_ovfd = 1'b0;
    n_checks++;
    if (k_ovf !== 1'b0) $display("FAIL clr_alone: ovf=%b want 0", k_ovf);
    else n_pass++;
    send_frame(8'h77, 3'd0, 1'b0, 1'b1);
    n_checks++;
    if (k_ovf !== m_ovfk || m_ovfk !== 1'b1 || d_ovf !== m_ovfd || d_count !== 5'(qd.size()))
      $display("FAIL set_vs_clr: kovf=%b dovf=%b dcount=%0d want 1 %b %0d",
               k_ovf, d_ovf, d_count, m_ovfd, qd.size());
    else n_pass++;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    m_ovfk = 1'b0;
    n_checks++;
    if (k_ovf !== 1'b0) $display("FAIL clr_after: ovf=%b want 0", k_ovf);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++)
      send_frame(8'($urandom), (i == 2) ? 3'b001 : 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    rx_valid = 1'b1; rx_byte = 8'h99; rx_err = 3'd0;
    @(negedge clk);
    @(negedge clk);                      // write edge is the next rising edge
    n_checks++;
    if (k_count !== 5'd5 || k_ecnt !== 8'd1)
      $display("FAIL pre_reset: count=%0d ecnt=%0d want 5 1", k_count, k_ecnt);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (k_valid !== 1'b0 || k_empty !== 1'b1 || k_full !== 1'b0 || k_count !== 5'd0 ||
        k_ecnt !== 8'd0 || k_ovf !== 1'b0 || d_count !== 5'd0)
      $display("FAIL async_reset: valid=%b empty=%b full=%b count=%0d ecnt=%0d ovf=%b want 0 1 0 0 0 0",
               k_valid, k_empty, k_full, k_count, k_ecnt, k_ovf);
    else n_pass++;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (8) @(negedge clk);
    n_checks++;
    if (k_count !== 5'd0 || k_empty !== 1'b1 || d_count !== 5'd0 || k_ecnt !== 8'd0)
      $display("FAIL post_reset: count=%0d empty=%b dcount=%0d ecnt=%0d want 0 1 0 0",
               k_count, k_empty, d_count, k_ecnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_fill_overflow();
    test_full_pop_and_wrap();
    test_error_frames();
    test_saturate_and_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the rx stage in uart. Captures each received frame (data byte plus 3-bit error code) on the rising edge of rx's valid strobe, brought into the i_Clk domain. Frames are queued in a first-word-fall-through FIFO with a valid/ready read port. Provides occupancy, overflow and error-frame accounting, so software or a downstream parser need not track baud timing.

Parameters:
DATA_W, 8, width of received data word
DEPTH, 16, FIFO entries; power of two, minimum 2
DROP_ERR, 0, 1 = discard frames with nonzero error code instead of queuing them

Ports:
i_Clk  in  1  system clock (100 MHz domain)
i_Rst  in  1  asynchronous, active-high reset
i_RX_valid  in  1  rx valid strobe, rxClk domain, high for at least 3 i_Clk cycles
i_RX_byte  in  DATA_W  rx data; stable from valid rise until at least 3 i_Clk cycles later
i_RX_error  in  3  rx error code; same stability as i_RX_byte
o_Data  out  DATA_W  head-of-queue data
o_Err  out  3  head-of-queue error code
o_Valid  out  1  head entry present
i_Ready  in  1  consumer accepts head when o_Valid & i_Ready
o_Count  out  $clog2(DEPTH)+1  entries stored, 0..DEPTH
o_Full  out  1  o_Count == DEPTH
o_Empty  out  1  o_Count == 0
o_Overflow  out  1  sticky: a frame was lost because the FIFO was full
i_Clr_Ovf  in  1  clears o_Overflow
o_Err_Cnt  out  8  frames received with nonzero error, saturating at 255

Behaviour:
- Reset (async assert, sync release): pointers, count, sync flops, o_Overflow and o_Err_Cnt go to 0. o_Valid=0, o_Empty=1, o_Full=0. Storage contents are not cleared. Reset mid-frame discards any pending capture.
- Capture: i_RX_valid passes through a 2-FF synchronizer, then a rising-edge detector. If the synchronizer first samples 1 at edge N, the push strobe is active in the cycle after edge N+1. i_RX_byte and i_RX_error are sampled at edge N+2, which is also the write edge. A level held high longer produces exactly one push. A new push requires valid to fall and rise again.
- Error accounting: every push with i_RX_error != 0 increments o_Err_Cnt (saturating), independent of DROP_ERR and FIFO state. With DROP_ERR=1, such a push writes nothing.
- FWFT read: o_Data/o_Err come combinationally from storage at the read pointer. o_Valid = !o_Empty. A written entry is visible after its write edge (o_Valid high the following cycle). Pop occurs on an edge where o_Valid & i_Ready.
- Pointers: $clog2(DEPTH) bits each, wrap modulo DEPTH. o_Count is maintained as a registered counter: +1 on write-only, -1 on pop-only, unchanged on both.
- Push when full without a pop in the same cycle: frame dropped, o_Count stays DEPTH, o_Overflow set.
- Push when full with a simultaneous pop: frame accepted, o_Count stays DEPTH, no overflow.
- Push when empty: no same-cycle pop is possible (o_Valid=0). o_Count goes 0 -> 1.
- o_Overflow: set has priority over i_Clr_Ovf in the same cycle. Otherwise i_Clr_Ovf clears it on the next edge.
- i_Ready while o_Valid=0 is ignored.

Decomposition:
- uart_pkg holds UART_ERR_W=3, the error-code localparams shared with rx (value 0 = no error), and the o_Err_Cnt width constant.
- One sub-module, uart_sync_edge: 2-FF synchronizer plus rising-edge pulse generator, with i_Clk/i_Rst. It is reusable for other rxClk/txClk-domain strobes.
- Storage, pointers and flags stay in uart_rx_fifo.

Test Plan:
1. Reset, then hold i_RX_valid high for 5 cycles with byte 0xA5, err 0 -> exactly one entry. o_Valid rises 3 cycles after the first sampled high. o_Data=0xA5, o_Count=1. Pop -> o_Empty=1.
2. Push 0x00..0x0F (16 frames) with i_Ready=0 -> o_Full=1, o_Count=16. Push 0x10 -> o_Overflow=1, o_Count=16. Drain -> 0x00..0x0F in order, 0x10 absent.
3. FIFO full and i_Ready=1 in the write cycle of push 0x55 -> no overflow, o_Count stays 16, 0x55 appears last after drain. Pointer wrap is exercised over 40 frames with no loss.
4. DROP_ERR=0, push 0x3C with err 3'b010 -> entry queued with o_Err=3'b010, o_Err_Cnt=1. DROP_ERR=1, same push -> o_Count unchanged, o_Err_Cnt=1.
5. 300 error frames -> o_Err_Cnt saturates at 255. An overflow event and i_Clr_Ovf in the same cycle -> o_Overflow stays 1. A clear alone the next cycle -> 0.
6. Assert i_Rst asynchronously with 5 entries queued and a push 1 cycle from its write edge -> all outputs return to reset values immediately, and no entry is written after release.
